// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - observed lamp/sensor inputs and monitor status outputs
interface traffic_light_monitor_if;
    logic        sensorA;
    logic        sensorB;
    logic        redLightA;
    logic        yellowLightA;
    logic        greenLightA;
    logic        redLightB;
    logic        yellowLightB;
    logic        greenLightB;
    logic        errClear;
    logic [2:0]  phase;
    logic        locked;
    logic [7:0]  dwell;
    logic        lampErr;
    logic        seqErr;
    logic        timeErr;
    logic        demandErr;
    logic        errPulse;
    logic [15:0] cycleCount;

    modport master (
        output sensorA, sensorB,
        output redLightA, yellowLightA, greenLightA,
        output redLightB, yellowLightB, greenLightB,
        output errClear,
        input  phase, locked, dwell,
        input  lampErr, seqErr, timeErr, demandErr, errPulse,
        input  cycleCount
    );

    modport slave (
        input  sensorA, sensorB,
        input  redLightA, yellowLightA, greenLightA,
        input  redLightB, yellowLightB, greenLightB,
        input  errClear,
        output phase, locked, dwell,
        output lampErr, seqErr, timeErr, demandErr, errPulse,
        output cycleCount
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker of a two-direction traffic light controller
module traffic_light_monitor #(
    parameter int MIN_GREEN_A = 6,
    parameter int MIN_GREEN_B = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_light_monitor_if.slave mon
);
    typedef enum logic [2:0] {
        PH_SYNC = 3'd0,
        PH_AG   = 3'd1,
        PH_AY   = 3'd2,
        PH_BG   = 3'd3,
        PH_BY   = 3'd4,
        PH_ILL  = 3'd7
    } phase_t;

    localparam logic [7:0] MIN_A = 8'(MIN_GREEN_A);
    localparam logic [7:0] MIN_B = 8'(MIN_GREEN_B);

    phase_t      obs;
    phase_t      phase_q, phase_d;
    phase_t      prev_obs_q, prev_obs_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        sens_a_q, sens_a_d;
    logic        sens_b_q, sens_b_d;
    logic        lamp_err_q, lamp_err_d;
    logic        seq_err_q, seq_err_d;
    logic        time_err_q, time_err_d;
    logic        demand_err_q, demand_err_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] cycle_count_q, cycle_count_d;

    logic [2:0]  lamps_a, lamps_b;
    logic        new_lamp, new_seq, new_time, new_demand, any_err, count_inc;
    logic        a_wants_to_leave, b_wants_to_leave;

    // Decode the six lamps into an observed phase; each direction must be exactly one-hot
    always_comb begin
        lamps_a = {mon.redLightA, mon.yellowLightA, mon.greenLightA};
        lamps_b = {mon.redLightB, mon.yellowLightB, mon.greenLightB};
        obs     = PH_ILL;
        if (lamps_a == 3'b001 && lamps_b == 3'b100)      obs = PH_AG;
        else if (lamps_a == 3'b010 && lamps_b == 3'b100) obs = PH_AY;
        else if (lamps_a == 3'b100 && lamps_b == 3'b001) obs = PH_BG;
        else if (lamps_a == 3'b100 && lamps_b == 3'b010) obs = PH_BY;
    end

    // Phase tracker: lock on a fresh AG, then check successor, timing and demand on every change
    always_comb begin
        phase_d    = phase_q;
        new_lamp   = 1'b0;
        new_seq    = 1'b0;
        new_time   = 1'b0;
        new_demand = 1'b0;
        count_inc  = 1'b0;
        // Demand seen by the controller one cycle earlier decides whether green may end
        a_wants_to_leave = sens_b_q;
        b_wants_to_leave = sens_a_q | ~sens_b_q;
        if (obs == PH_ILL) begin
            new_lamp = 1'b1;
        end else if (phase_q == PH_SYNC) begin
            if (obs == PH_AG && prev_obs_q != PH_AG) phase_d = PH_AG;
        end else begin
            case (phase_q)
                PH_AG: begin
                    if (obs == PH_AG) begin
                        if (dwell_q >= MIN_A && a_wants_to_leave) new_demand = 1'b1;
                    end else if (obs == PH_AY) begin
                        if (dwell_q < MIN_A)   new_time   = 1'b1;
                        if (!a_wants_to_leave) new_demand = 1'b1;
                    end else begin
                        new_seq = 1'b1;
                    end
                end
                PH_AY: begin
                    if (obs == PH_AY)      new_time = 1'b1;
                    else if (obs != PH_BG) new_seq  = 1'b1;
                end
                PH_BG: begin
                    if (obs == PH_BG) begin
                        if (dwell_q >= MIN_B && b_wants_to_leave) new_demand = 1'b1;
                    end else if (obs == PH_BY) begin
                        if (dwell_q < MIN_B)   new_time   = 1'b1;
                        if (!b_wants_to_leave) new_demand = 1'b1;
                    end else begin
                        new_seq = 1'b1;
                    end
                end
                PH_BY: begin
                    if (obs == PH_BY)      new_time  = 1'b1;
                    else if (obs == PH_AG) count_inc = 1'b1;
                    else                   new_seq   = 1'b1;
                end
                default: new_seq = 1'b1;
            endcase
            phase_d = obs;
        end
        any_err = new_lamp | new_seq | new_time | new_demand;
        if (any_err) begin
            phase_d   = PH_SYNC;
            count_inc = 1'b0;
        end
    end

    // History, dwell counter, sticky flags and completed-cycle counter
    always_comb begin
        prev_obs_d    = obs;
        sens_a_d      = mon.sensorA;
        sens_b_d      = mon.sensorB;
        dwell_d       = (obs != prev_obs_q) ? 8'd1 :
                        (dwell_q == 8'hFF)  ? 8'hFF : dwell_q + 8'd1;
        // A clear and a fresh error in the same cycle leave the fresh flag set
        lamp_err_d    = (lamp_err_q   & ~mon.errClear) | new_lamp;
        seq_err_d     = (seq_err_q    & ~mon.errClear) | new_seq;
        time_err_d    = (time_err_q   & ~mon.errClear) | new_time;
        demand_err_d  = (demand_err_q & ~mon.errClear) | new_demand;
        err_pulse_d   = any_err;
        cycle_count_d = cycle_count_q + {15'd0, count_inc};
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_SYNC;
            prev_obs_q    <= PH_ILL;
            dwell_q       <= 8'd0;
            sens_a_q      <= 1'b0;
            sens_b_q      <= 1'b0;
            lamp_err_q    <= 1'b0;
            seq_err_q     <= 1'b0;
            time_err_q    <= 1'b0;
            demand_err_q  <= 1'b0;
            err_pulse_q   <= 1'b0;
            cycle_count_q <= 16'd0;
        end else begin
            phase_q       <= phase_d;
            prev_obs_q    <= prev_obs_d;
            dwell_q       <= dwell_d;
            sens_a_q      <= sens_a_d;
            sens_b_q      <= sens_b_d;
            lamp_err_q    <= lamp_err_d;
            seq_err_q     <= seq_err_d;
            time_err_q    <= time_err_d;
            demand_err_q  <= demand_err_d;
            err_pulse_q   <= err_pulse_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign mon.phase      = phase_q;
    assign mon.locked     = (phase_q != PH_SYNC);
    assign mon.dwell      = dwell_q;
    assign mon.lampErr    = lamp_err_q;
    assign mon.seqErr     = seq_err_q;
    assign mon.timeErr    = time_err_q;
    assign mon.demandErr  = demand_err_q;
    assign mon.errPulse   = err_pulse_q;
    assign mon.cycleCount = cycle_count_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - table, corner-case and random checks of traffic_light_monitor
module tb_traffic_light_monitor;
    localparam int MIN_A = 6;
    localparam int MIN_B = 5;
    // Lamp patterns ordered {rA, yA, gA, rB, yB, gB}
    localparam logic [5:0] L_AG = 6'b001100;
    localparam logic [5:0] L_AY = 6'b010100;
    localparam logic [5:0] L_BG = 6'b100001;
    localparam logic [5:0] L_BY = 6'b100010;
    localparam logic [5:0] L_GG = 6'b001001;

    logic clk = 1'b0;
    logic rst;
    traffic_light_monitor_if bus();

    traffic_light_monitor #(.MIN_GREEN_A(MIN_A), .MIN_GREEN_B(MIN_B)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: phases 0 SYNC, 1 AG, 2 AY, 3 BG, 4 BY, 7 illegal
    int       m_phase, m_prev, m_dwell, m_count;
    bit       m_sa, m_sb, m_pulse;
    bit [3:0] m_flags;   // {lamp, seq, time, demand}

    function automatic int decode(input logic [5:0] l);
        if (l == L_AG) return 1;
        if (l == L_AY) return 2;
        if (l == L_BG) return 3;
        if (l == L_BY) return 4;
        return 7;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_prev = 7; m_dwell = 0; m_count = 0;
        m_sa = 0; m_sb = 0; m_pulse = 0; m_flags = 4'b0000;
    endtask

    task automatic model_step(input logic [5:0] l, input bit sa, input bit sb, input bit ec, input bit r);
        int obs, nd, nxt, mg;
        bit green, want;
        bit [3:0] ev;
        if (r) begin
            model_reset();
            return;
        end
        obs = decode(l);
        nd  = (obs != m_prev) ? 1 : ((m_dwell < 255) ? m_dwell + 1 : 255);
        ev  = 4'b0000;
        nxt = m_phase;
        if (obs == 7) begin
            ev[3] = 1'b1;
            nxt   = 0;
        end else if (m_phase == 0) begin
            if (obs == 1 && m_prev != 1) nxt = 1;
        end else begin
            green = (m_phase % 2) == 1;
            mg    = (m_phase == 1) ? MIN_A : MIN_B;
            want  = (m_phase == 1) ? m_sb : (m_sa | !m_sb);
            if (obs == m_phase) begin
                if (!green) ev[1] = 1'b1;
                else if (m_dwell >= mg && want) ev[0] = 1'b1;
            end else if (obs == (m_phase % 4) + 1) begin
                if (green) begin
                    if (m_dwell < mg) ev[1] = 1'b1;
                    if (!want)        ev[0] = 1'b1;
                end else if (m_phase == 4) begin
                    m_count = (m_count + 1) % 65536;
                end
            end else begin
                ev[2] = 1'b1;
            end
            nxt = (ev != 4'b0000) ? 0 : obs;
        end
        m_flags = (ec ? 4'b0000 : m_flags) | ev;
        m_pulse = (ev != 4'b0000);
        m_phase = nxt;
        m_prev  = obs;
        m_dwell = nd;
        m_sa    = sa;
        m_sb    = sb;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] l, input bit sa, input bit sb, input bit ec, input bit r);
        @(negedge clk);
        {bus.redLightA, bus.yellowLightA, bus.greenLightA,
         bus.redLightB, bus.yellowLightB, bus.greenLightB} = l;
        bus.sensorA  = sa;
        bus.sensorB  = sb;
        bus.errClear = ec;
        rst          = r;
        model_step(l, sa, sb, ec, r);
        @(posedge clk);
        #1;
    endtask

    function automatic int flags_now();
        return int'({bus.lampErr, bus.seqErr, bus.timeErr, bus.demandErr});
    endfunction

    task automatic check_model(input string tag);
        check({tag, " phase"},  int'(bus.phase),      m_phase);
        check({tag, " locked"}, int'(bus.locked),     int'(m_phase != 0));
        check({tag, " dwell"},  int'(bus.dwell),      m_dwell);
        check({tag, " flags"},  flags_now(),          int'(m_flags));
        check({tag, " pulse"},  int'(bus.errPulse),   int'(m_pulse));
        check({tag, " count"},  int'(bus.cycleCount), m_count);
    endtask

    typedef struct {
        logic [5:0] l;
        bit         sa, sb, ec, r;
        int         ph, dw;
        bit [3:0]   fl;
        bit         pu;
        int         cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [5:0] l, input bit sb, input bit ec, input bit r,
                       input int ph, input int dw, input bit [3:0] fl, input bit pu, input int cnt);
        vec_t v;
        v.l = l; v.sa = 1'b0; v.sb = sb; v.ec = ec; v.r = r;
        v.ph = ph; v.dw = dw; v.fl = fl; v.pu = pu; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic rand_phase(input logic [5:0] l, input int len, input int kind);
        for (int k = 0; k < len; k++) begin
            bit last, sa, sb;
            logic [5:0] lp;
            last = (k == len - 1);
            sa   = ($urandom_range(0, 7) == 0);
            lp   = l;
            if (kind == 1)      sb = last ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            else if (kind == 2) sb = last ? ($urandom_range(0, 3) == 0) : 1'b1;
            else                sb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) lp = 6'($urandom_range(0, 63));
            drive(lp, sa, sb, $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
            check_model("rand");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {bus.redLightA, bus.yellowLightA, bus.greenLightA,
         bus.redLightB, bus.yellowLightB, bus.greenLightB} = L_AG;
        bus.sensorA = 1'b0; bus.sensorB = 1'b0; bus.errClear = 1'b0;
        model_reset();

        // Full legal cycle, lamp error, short green, missed demand, bad successor, clear race, reset
        add(L_AG, 0, 0, 1, 0, 0, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 1, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 2, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 3, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 4, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 5, 4'b0000, 0, 0);
        add(L_AG, 1, 0, 0, 1, 6, 4'b0000, 0, 0);
        add(L_AY, 0, 0, 0, 2, 1, 4'b0000, 0, 0);
        add(L_BG, 1, 0, 0, 3, 1, 4'b0000, 0, 0);
        add(L_BG, 1, 0, 0, 3, 2, 4'b0000, 0, 0);
        add(L_BG, 1, 0, 0, 3, 3, 4'b0000, 0, 0);
        add(L_BG, 1, 0, 0, 3, 4, 4'b0000, 0, 0);
        add(L_BG, 0, 0, 0, 3, 5, 4'b0000, 0, 0);
        add(L_BY, 0, 0, 0, 4, 1, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 1, 4'b0000, 0, 1);
        add(L_GG, 0, 0, 0, 0, 1, 4'b1000, 1, 1);
        add(L_AG, 0, 0, 0, 1, 1, 4'b1000, 0, 1);
        add(L_AG, 0, 1, 0, 1, 2, 4'b0000, 0, 1);
        add(L_AG, 0, 0, 0, 1, 3, 4'b0000, 0, 1);
        add(L_AG, 1, 0, 0, 1, 4, 4'b0000, 0, 1);
        add(L_AY, 0, 0, 0, 0, 1, 4'b0010, 1, 1);
        add(L_BG, 0, 0, 0, 0, 1, 4'b0010, 0, 1);
        add(L_BY, 0, 0, 0, 0, 1, 4'b0010, 0, 1);
        add(L_AG, 0, 0, 0, 1, 1, 4'b0010, 0, 1);
        add(L_AG, 0, 0, 0, 1, 2, 4'b0010, 0, 1);
        add(L_AG, 0, 0, 0, 1, 3, 4'b0010, 0, 1);
        add(L_AG, 0, 0, 0, 1, 4, 4'b0010, 0, 1);
        add(L_AG, 0, 0, 0, 1, 5, 4'b0010, 0, 1);
        add(L_AG, 1, 0, 0, 1, 6, 4'b0010, 0, 1);
        add(L_AG, 1, 0, 0, 0, 7, 4'b0011, 1, 1);
        add(L_AG, 0, 1, 0, 0, 8, 4'b0000, 0, 1);
        add(L_BY, 0, 0, 0, 0, 1, 4'b0000, 0, 1);
        add(L_AG, 0, 0, 0, 1, 1, 4'b0000, 0, 1);
        add(L_BG, 0, 0, 0, 0, 1, 4'b0100, 1, 1);
        add(L_AG, 0, 0, 0, 1, 1, 4'b0100, 0, 1);
        add(L_BG, 0, 1, 0, 0, 1, 4'b0100, 1, 1);
        add(L_BG, 0, 0, 1, 0, 0, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 1, 4'b0000, 0, 0);
        add(L_AG, 0, 0, 0, 1, 2, 4'b0000, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].l, tbl[i].sa, tbl[i].sb, tbl[i].ec, tbl[i].r);
            check($sformatf("vec%0d phase", i),  int'(bus.phase),      tbl[i].ph);
            check($sformatf("vec%0d locked", i), int'(bus.locked),     int'(tbl[i].ph != 0));
            check($sformatf("vec%0d dwell", i),  int'(bus.dwell),      tbl[i].dw);
            check($sformatf("vec%0d flags", i),  flags_now(),          int'(tbl[i].fl));
            check($sformatf("vec%0d pulse", i),  int'(bus.errPulse),   int'(tbl[i].pu));
            check($sformatf("vec%0d count", i),  int'(bus.cycleCount), tbl[i].cnt);
        end

        // Counter wrap: preload 65535 completed cycles, then one more legal cycle
        drive(L_BY, 0, 0, 0, 1);
        force dut.cycle_count_q = 16'hFFFF;
        #1;
        release dut.cycle_count_q;
        m_count = 65535;
        for (int k = 0; k < MIN_A; k++) begin
            drive(L_AG, 0, k == MIN_A - 1, 0, 0);
            check_model("wrap ag");
        end
        drive(L_AY, 0, 0, 0, 0);
        check_model("wrap ay");
        for (int k = 0; k < MIN_B; k++) begin
            drive(L_BG, 0, k != MIN_B - 1, 0, 0);
            check_model("wrap bg");
        end
        drive(L_BY, 0, 0, 0, 0);
        check_model("wrap by");
        drive(L_AG, 0, 0, 0, 0);
        check("wrap count zero", int'(bus.cycleCount), 0);
        check("wrap no error", flags_now(), 0);

        // Long AG hold without demand: dwell saturates, no error
        for (int k = 0; k < 300; k++) begin
            drive(L_AG, 0, 0, 0, 0);
            check_model("hold");
        end
        check("hold dwell sat", int'(bus.dwell), 255);
        check("hold flags", flags_now(), 0);
        check("hold phase", int'(bus.phase), 1);

        // Randomized controller-like traffic with glitches, clears and resets
        for (int seg = 0; seg < 150; seg++) begin
            rand_phase(L_AG, int'($urandom_range(1, 9)), 1);
            if ($urandom_range(0, 11) != 0)
                rand_phase(L_AY, ($urandom_range(0, 7) == 0) ? 2 : 1, 0);
            rand_phase(L_BG, int'($urandom_range(1, 8)), 2);
            if ($urandom_range(0, 11) != 0)
                rand_phase(L_BY, ($urandom_range(0, 7) == 0) ? 2 : 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter MIN_GREEN_A, default 6: minimum consecutive A-green/B-red cycles before the A-yellow phase.
REQ-002 Parameter MIN_GREEN_B, default 5: minimum consecutive B-green/A-red cycles before the B-yellow phase.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sensorA  input  1  A-direction demand, the same signal the controller sees.
REQ-006 sensorB  input  1  B-direction demand, the same signal the controller sees.
REQ-007 redLightA, yellowLightA, greenLightA  input  1 each  observed A lamps.
REQ-008 redLightB, yellowLightB, greenLightB  input  1 each  observed B lamps.
REQ-009 errClear  input  1  clears all sticky error flags.
REQ-010 phase  output  3  tracked FSM state: 0 SYNC, 1 AG, 2 AY, 3 BG, 4 BY.
REQ-011 locked  output  1  high when phase is not SYNC.
REQ-012 dwell  output  8  cycles spent in the current observed phase, saturating.
REQ-013 lampErr, seqErr, timeErr, demandErr  output  1 each  sticky error flags.
REQ-014 errPulse  output  1  one-cycle strobe on any newly detected error.
REQ-015 cycleCount  output  16  count of completed AG-AY-BG-BY cycles, wrapping.

Function
REQ-016 Each cycle the lamps SHALL decode to an observed phase:
  - AG = gA&rB
  - AY = yA&rB
  - BG = rA&gB
  - BY = rA&yB
  - ILL = any other pattern, including more than one lamp lit per direction, no lamp lit, or both directions non-red.
REQ-017 All outputs SHALL be registered and SHALL reflect the inputs sampled at the same rising edge; there is no other latency.
REQ-018 The block SHALL register prevObs (the previous observed phase) and the previous values of sensorA and sensorB.
REQ-019 dwell SHALL load 1 when the observed phase differs from prevObs, and otherwise increment, saturating at 255.
REQ-020 ILL in any state SHALL set lampErr, pulse errPulse and force SYNC; lampErr has precedence, so no other flag is set that cycle.
REQ-021 SYNC SHALL go to AG only when obs=AG and prevObs!=AG; in SYNC no sequence, time or demand checks apply.
REQ-022 Legal successors SHALL be AG->AY, AY->BG, BG->BY and BY->AG; any other change of observed phase SHALL set seqErr and force SYNC.
REQ-023 AG->AY SHALL require the AG dwell to be >=MIN_GREEN_A and BG->BY SHALL require the BG dwell to be >=MIN_GREEN_B; otherwise timeErr is set.
REQ-024 AY and BY SHALL last exactly 1 cycle; a second consecutive cycle SHALL set timeErr.
REQ-025 AG->AY SHALL require the previous sensorB=1; otherwise demandErr is set.
REQ-026 AG persisting with dwell >=MIN_GREEN_A and previous sensorB=1 SHALL set demandErr (missed demand).
REQ-027 BG->BY SHALL require previous (sensorA | ~sensorB)=1; otherwise demandErr is set.
REQ-028 BG persisting with dwell >=MIN_GREEN_B and previous (sensorA | ~sensorB)=1 SHALL set demandErr.
REQ-029 Any seqErr, timeErr or demandErr event SHALL force SYNC.
REQ-030 Multiple non-lamp errors in one cycle SHALL all set their flags, with one errPulse.
REQ-031 A legal BY->AG transition without error SHALL increment cycleCount, wrapping 0xFFFF->0x0000.
REQ-032 errClear SHALL clear all sticky flags; a new error in the same cycle SHALL take precedence, leaving its flag set.
REQ-033 In SYNC, dwell SHALL keep counting so that it continues to reflect the observed phase.

Reset
REQ-034 rst SHALL set the following, taking priority over all other inputs:
  - phase = SYNC, locked = 0
  - dwell = 0, cycleCount = 0
  - all error flags = 0, errPulse = 0
  - prevObs = ILL, registered sensors = 0.
REQ-035 Asserting rst mid-phase SHALL discard all tracking; after release the monitor relocks on the first AG sample.

Verification
REQ-036 Reset, then 6 AG cycles (sensorB=1 on cycle 6), 1 AY, 5 BG (sensorB=0 on cycle 5), 1 BY, AG -> locked from cycle 1, cycleCount=1, no error flags.
REQ-037 Lamps gA=1, gB=1 for 1 cycle while locked -> lampErr=1, errPulse for 1 cycle, phase=0.
REQ-038 AG for 4 cycles, then AY -> timeErr=1, phase=0; relock only after BY->AG or a fresh AG entry.
REQ-039 AG with sensorB=1 from cycle 6, still AG at cycle 7 -> demandErr=1; then errClear=1 -> all flags 0.
REQ-040 AG then BG directly -> seqErr=1, errPulse=1, phase=0, cycleCount unchanged.
REQ-041 Preload 65535 completed cycles then one more legal cycle -> cycleCount=0; 300-cycle AG hold with sensorB=0 -> dwell holds at 255, no error.
